ahb_bus_arbiter: RTL and testbench
==================================

# ahb_bus_arbiter

Shares the AHB bus between `NUM_MASTERS` masters, each driving `hbusreq`/`hlock` and receiving `hgrant`. It sits between the master-side interfaces and the address/data multiplexers. It produces the one-hot grant, the `hmaster` index that steers the muxes, and `hmastlock` for the slaves. Arbitration is round-robin. Grants never break a locked sequence or a fixed-length burst. Ownership hands over only on `hready`-high edges.

## Interface
- `NUM_MASTERS`, default 4: number of requesters, legal range 2..16.
- `DEFAULT_MASTER`, default 0: index granted when no master requests.

- `hclk`  in  1  bus clock; all state updates on its rising edge.
- `hreset`  in  1  asynchronous, active-low reset.
- `hbusreq`  in  NUM_MASTERS  per-master bus request.
- `hlock`  in  NUM_MASTERS  per-master locked-access request.
- `htrans`  in  2  muxed bus transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `hburst`  in  3  muxed burst type: 0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16.
- `hready`  in  1  transfer-done from the slave mux.
- `hresp`  in  2  response: 0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT.
- `hgrant`  out  NUM_MASTERS  registered, one-hot grant.
- `hmaster`  out  4  registered index of the address-phase owner.
- `hmastlock`  out  1  registered; the current address phase is locked.

## Operation
- **Reset values.** While `hreset` is low:
  - `hgrant` is one-hot at `DEFAULT_MASTER`.
  - `hmaster` = `DEFAULT_MASTER`.
  - `hmastlock` = 0.
  - The beat counter is 0.
  - The round-robin pointer = `DEFAULT_MASTER`.
- **Beat counter (4 bits).** It tracks the remaining beats of the owner's fixed-length burst. On an edge with `hready`=1:
  - NONSEQ loads the burst length minus 1: 3 for WRAP4/INCR4, 7 for 8-beat bursts, 15 for 16-beat bursts, 0 for SINGLE and INCR.
  - SEQ decrements the counter, saturating at 0.
  - IDLE clears the counter.
  - BUSY holds the counter.
- **Non-OKAY response.** `hresp`≠OKAY clears the counter on any edge, regardless of `hready`. The burst is terminated.
- **next_count.** This is the counter value after the current edge.
- **lock_hold.** True when `hlock[g]`=1, where g is the currently granted index.
- **rearb_ok.** Equals (next_count==0) AND NOT lock_hold. INCR (undefined length) is therefore re-arbitrable on any beat.
- **Grant update, when rearb_ok.** `hgrant` is loaded with the first requesting master found by searching from pointer+1 upward, wrapping modulo `NUM_MASTERS`. The pointer itself is checked last. If no `hbusreq` bit is set, `DEFAULT_MASTER` is granted. The pointer becomes the new grant index whenever the grant comes from a request.
- **Grant update, when not rearb_ok.** `hgrant` holds, even if the owner deasserts `hbusreq`.
- **Handover.** On an edge with `hready`=1:
  - `hmaster` takes the index of `hgrant` as it stood before that edge.
  - `hmastlock` takes `hlock` of that same index.
- **Stall.** With `hready`=0, `hmaster` and `hmastlock` hold.
- **Simultaneous requests.** Fairness is strictly by pointer rotation. No master wins twice in a row while another is requesting, unless lock or burst protection applies.
- **Request/grant integrity.** A requester is never granted without its `hbusreq`. The only exception is the default grant.
- **Reset mid-operation.** The asynchronous assert immediately forces all reset values, whatever burst or lock is in progress.

## Timing
- **Idle-bus latency.** `hbusreq[i]` rises in cycle 0 → `hgrant[i]` at edge 1 → `hmaster`=i at edge 2, given `hready`=1 at edge 2.
- **Burst boundary.** For a 4-beat burst with NONSEQ at edge k, re-arbitration occurs at the edge of the final beat (k+3, where next_count becomes 0). The new grant is visible after k+3, and the new `hmaster` follows after the next `hready` edge.
- **Grant stability.** `hgrant` changes at most once per cycle and is always one-hot. `hmaster` can only change on `hready`-high edges.
- **Wait states.** `hready`=0 freezes the counter. The only exception is a non-OKAY `hresp`, which clears it.

## Test plan
- **Reset.** `hreset` low mid-burst → `hgrant`=0001, `hmaster`=0, `hmastlock`=0 immediately. After release with no requests, the grant stays at 0001.
- **Round-robin.** `hbusreq`=1111 held with SINGLE transfers and `hready`=1 → `hmaster` sequence 1,2,3,0,1, changing one per cycle after the initial two-cycle latency.
- **Burst protection.** Master 2 issues an INCR8 while master 1 requests → `hgrant` stays at 0100 for 7 edges after NONSEQ and changes to 0010 on the 8th-beat edge.
- **Lock.** Master 3 asserts `hlock` with INCR for 5 beats while masters 0 and 1 request → grant held at 3 and `hmastlock`=1 throughout. Grant moves to master 0 one edge after `hlock` drops.
- **Early termination.** Master 1's INCR16 receives ERROR at beat 4 → the counter clears and the pending master 2 is granted at that edge.
- **Wait states.** `hready`=0 for 3 cycles at handover → `hmaster` holds its old value and updates on the first `hready`=1 edge.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with burst and lock protection.
// Grant changes follow the beat counter; hmaster follows grant on hready.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] DEF = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);
  localparam logic [IW:0] NM = (IW+1)'(NUM_MASTERS);

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_BUSY   = 2'd1,
    T_NONSEQ = 2'd2,
    T_SEQ    = 2'd3
  } trans_e;

  logic [3:0]    count_q;
  logic [3:0]    next_count;
  logic [3:0]    burst_len;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic          found;
  logic          lock_hold;
  logic          rearb_ok;

  always_comb begin
    unique case (hburst[2:1])
      2'b00:   burst_len = 4'd0;
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      default: burst_len = 4'd15;
    endcase
  end

  // An error-class response ends the burst even during wait states
  always_comb begin
    next_count = count_q;
    if (hresp != 2'b00) begin
      next_count = 4'd0;
    end else if (hready) begin
      unique case (trans_e'(htrans))
        T_IDLE:   next_count = 4'd0;
        T_BUSY:   next_count = count_q;
        T_NONSEQ: next_count = burst_len;
        T_SEQ:    next_count = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
      endcase
    end
  end

  // Search starts just past the pointer; the pointer itself is last
  always_comb begin
    pick  = DEF;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= NM) cand = cand - NM;
      if (!found && hbusreq[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign lock_hold = hlock[grant_q];
  assign rearb_ok  = (next_count == 4'd0) && !lock_hold;

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      count_q   <= 4'd0;
      grant_q   <= DEF;
      ptr_q     <= DEF;
      hgrant    <= ONE << DEF;
      hmaster   <= 4'(DEF);
      hmastlock <= 1'b0;
    end else begin
      count_q <= next_count;
      if (rearb_ok) begin
        grant_q <= pick;
        hgrant  <= ONE << pick;
        if (found) ptr_q <= pick;
      end
      if (hready) begin
        hmaster   <= 4'(grant_q);
        hmastlock <= hlock[grant_q];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbiter model.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         hclk;
  logic         hreset;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [1:0]   hresp;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;

  int tests = 0;
  int fails = 0;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Behavioural model: plain integers, rules applied edge by edge
  int m_cnt  = 0;
  int m_g    = DEF;
  int m_ptr  = DEF;
  int m_mst  = DEF;
  bit m_lock = 1'b0;
  int nc, blen, old_g, c;
  bit hit;

  always @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      m_cnt  = 0;
      m_g    = DEF;
      m_ptr  = DEF;
      m_mst  = DEF;
      m_lock = 1'b0;
    end else begin
      if (hburst >= 6)      blen = 15;
      else if (hburst >= 4) blen = 7;
      else if (hburst >= 2) blen = 3;
      else                  blen = 0;
      if (hresp != 0)       nc = 0;
      else if (!hready)     nc = m_cnt;
      else if (htrans == 0) nc = 0;
      else if (htrans == 1) nc = m_cnt;
      else if (htrans == 2) nc = blen;
      else                  nc = (m_cnt > 0) ? m_cnt - 1 : 0;
      old_g = m_g;
      if (nc == 0 && !hlock[m_g]) begin
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (!hit && hbusreq[c]) begin
            hit = 1'b1;
            m_g = c;
          end
        end
        if (hit) m_ptr = m_g;
        else     m_g = DEF;
      end
      if (hready) begin
        m_mst  = old_g;
        m_lock = hlock[old_g];
      end
      m_cnt = nc;
    end
  end

  always @(negedge hclk) begin
    tests++;
    if (hgrant !== N'(1 << m_g) || hmaster !== 4'(m_mst) ||
        hmastlock !== m_lock) begin
      fails++;
      $display("FAIL model t=%0t: hgrant=%b exp %b hmaster=%0d exp %0d hmastlock=%b exp %b",
               $time, hgrant, N'(1 << m_g), hmaster, m_mst, hmastlock, m_lock);
    end
  end

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic [1:0] rs);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rs;
    @(posedge hclk);
    #1;
  endtask

  int rr_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    hreset  = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = 2'd0;
    hburst  = 3'd0;
    hready  = 1'b1;
    hresp   = 2'd0;
    #11;
    lit("reset_hgrant", 32'(hgrant), 32'h1);
    lit("reset_hmaster", 32'(hmaster), 32'h0);
    lit("reset_hmastlock", 32'(hmastlock), 32'h0);
    #1 hreset = 1'b1;
    step(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    step(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    lit("idle_default_grant", 32'(hgrant), 32'h1);

    // Round-robin with single transfers
    step(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    lit("rr_first_grant", 32'(hgrant), 32'h2);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
      lit($sformatf("rr_hmaster_%0d", i), 32'(hmaster), 32'(rr_exp[i]));
    end

    // Master 2 owns an INCR8 while master 1 waits
    step(4'b0110, 4'b0000, 2'd2, 3'd5, 1'b1, 2'd0);
    for (int i = 0; i < 6; i++)
      step(4'b0110, 4'b0000, 2'd3, 3'd5, 1'b1, 2'd0);
    lit("burst_held", 32'(hgrant), 32'h4);
    step(4'b0110, 4'b0000, 2'd3, 3'd5, 1'b1, 2'd0);
    lit("burst_handover", 32'(hgrant), 32'h2);
    lit("burst_hmaster", 32'(hmaster), 32'h2);

    // Locked INCR from master 3 against masters 0 and 1
    step(4'b1011, 4'b1000, 2'd0, 3'd1, 1'b1, 2'd0);
    lit("lock_grant3", 32'(hgrant), 32'h8);
    step(4'b1011, 4'b1000, 2'd2, 3'd1, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++)
      step(4'b1011, 4'b1000, 2'd3, 3'd1, 1'b1, 2'd0);
    lit("lock_held", 32'(hgrant), 32'h8);
    lit("lock_mastlock", 32'(hmastlock), 32'h1);
    lit("lock_hmaster", 32'(hmaster), 32'h3);
    step(4'b1011, 4'b0000, 2'd0, 3'd1, 1'b1, 2'd0);
    lit("unlock_grant0", 32'(hgrant), 32'h1);
    lit("unlock_mastlock", 32'(hmastlock), 32'h0);

    // INCR16 from master 1 ends early on ERROR (first, hready low cycle)
    step(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    step(4'b0110, 4'b0000, 2'd2, 3'd7, 1'b1, 2'd0);
    step(4'b0110, 4'b0000, 2'd3, 3'd7, 1'b1, 2'd0);
    step(4'b0110, 4'b0000, 2'd3, 3'd7, 1'b1, 2'd0);
    lit("err_before", 32'(hgrant), 32'h2);
    step(4'b0110, 4'b0000, 2'd3, 3'd7, 1'b0, 2'd1);
    lit("err_grant2", 32'(hgrant), 32'h4);

    // Wait states across the handover
    for (int i = 0; i < 3; i++)
      step(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b0, 2'd0);
    lit("wait_hold", 32'(hmaster), 32'h1);
    step(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    lit("wait_release", 32'(hmaster), 32'h2);

    // Asynchronous reset in the middle of a locked burst
    step(4'b0100, 4'b0100, 2'd2, 3'd3, 1'b1, 2'd0);
    step(4'b0100, 4'b0100, 2'd3, 3'd3, 1'b1, 2'd0);
    lit("pre_reset_mastlock", 32'(hmastlock), 32'h1);
    #2 hreset = 1'b0;
    #1;
    lit("midrst_hgrant", 32'(hgrant), 32'h1);
    lit("midrst_hmaster", 32'(hmaster), 32'h0);
    lit("midrst_hmastlock", 32'(hmastlock), 32'h0);
    @(negedge hclk);
    #2 hreset = 1'b1;
    @(posedge hclk);
    #1;
    step(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    step(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    lit("post_reset_idle", 32'(hgrant), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rq, lk;
      logic rd;
      logic [1:0] rs;
      rq = N'($urandom);
      lk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rd = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 299) == 0) begin
        hreset = 1'b0;
        #3 hreset = 1'b1;
      end
      step(rq, lk, 2'($urandom), 3'($urandom), rd, rs);
    end

    @(negedge hclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
